dac_update_scheduler: RTL

Arbitrates the DAC register RAM write port between the host local-bus path and an on-chip feedback requester, and sequences DAC load (update) cycles against the serial DAC loader's busy handshake. Sits between the bus interface / feedback logic and the DAC loader. Replaces the direct host-driven write and update strobes with a scheduled, non-overlapping sequence.

---
 rtl/dac_update_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dac_update_scheduler.sv
// DAC register RAM write arbiter (host vs. feedback) and update sequencer that
// issues non-overlapping load pulses against the serial loader's busy handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no load in flight; feedback writes and new updates allowed
// WAIT_BUSY  | update pulsed, waiting for dac_busy_i to rise (timed)
// LOAD       | loader busy; waiting for dac_busy_i to fall
module dac_update_scheduler #(
    parameter int NUM_ADDR_W   = 5,
    parameter int DAT_W        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  host_wr_i,
    input  logic [NUM_ADDR_W-1:0] host_addr_i,
    input  logic [DAT_W-1:0]      host_dat_i,
    input  logic                  fb_req_i,
    input  logic [NUM_ADDR_W-1:0] fb_addr_i,
    input  logic [DAT_W-1:0]      fb_dat_i,
    output logic                  fb_ack_o,
    input  logic                  update_req_i,
    input  logic                  auto_update_i,
    input  logic                  err_clr_i,
    input  logic                  dac_busy_i,
    output logic                  dac_wr_o,
    output logic [NUM_ADDR_W-1:0] dac_waddr_o,
    output logic [DAT_W-1:0]      dac_dat_o,
    output logic                  dac_update_o,
    output logic                  dirty_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [7:0]            update_count_o
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_LOAD      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmr_q;
    logic             pend_q;
    logic             dirty_q;
    logic             fb_grant;
    logic             wr_grant;
    logic             trig;
    logic             upd_start;
    logic             tmo;
    logic             load_done;

    // Feedback is blocked while its own ack is showing so a held request
    // cannot be written twice.
    assign fb_grant = !host_wr_i && fb_req_i && !fb_ack_o && (state_q == ST_IDLE);
    assign wr_grant = host_wr_i | fb_grant;
    assign trig     = update_req_i | pend_q | (auto_update_i & dirty_q);

    assign dirty_o  = dirty_q;
    assign busy_o   = (state_q != ST_IDLE) | pend_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        upd_start = 1'b0;
        tmo       = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig && !wr_grant && !dac_busy_i) begin
                    upd_start = 1'b1;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (dac_busy_i) begin
                    state_d = ST_LOAD;
                end else if (tmr_q == '0) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!dac_busy_i) begin
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer is loaded with TIMEOUT-1 so the terminal compare at zero lands
    // exactly BUSY_TIMEOUT edges after the update pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_q <= '0;
        end else if (upd_start) begin
            tmr_q <= TMR_LOAD;
        end else if (state_q == ST_WAIT_BUSY && !dac_busy_i && tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dac_wr_o    <= 1'b0;
            fb_ack_o    <= 1'b0;
            dac_waddr_o <= '0;
            dac_dat_o   <= '0;
        end else begin
            dac_wr_o <= wr_grant;
            fb_ack_o <= fb_grant;
            if (host_wr_i) begin
                dac_waddr_o <= host_addr_i;
                dac_dat_o   <= host_dat_i;
            end else if (fb_grant) begin
                dac_waddr_o <= fb_addr_i;
                dac_dat_o   <= fb_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dac_update_o   <= 1'b0;
            pend_q         <= 1'b0;
            dirty_q        <= 1'b0;
            err_o          <= 1'b0;
            update_count_o <= '0;
        end else begin
            dac_update_o <= upd_start;

            if (upd_start) begin
                pend_q <= 1'b0;
            end else if (update_req_i) begin
                pend_q <= 1'b1;
            end

            if (wr_grant) begin
                dirty_q <= 1'b1;
            end else if (upd_start) begin
                dirty_q <= 1'b0;
            end

            if (tmo) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end

            if (load_done) begin
                update_count_o <= update_count_o + 8'd1;
            end
        end
    end

endmodule
